// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM state encodings and
// the pipeline control constants used alongside them.
package mem_port_arbiter_pkg;

   localparam logic [2:0] ARB_IDLE   = 3'd0;
   localparam logic [2:0] ARB_REQ_I  = 3'd1;
   localparam logic [2:0] ARB_WAIT_I = 3'd2;
   localparam logic [2:0] ARB_REQ_D  = 3'd3;
   localparam logic [2:0] ARB_WAIT_D = 3'd4;

   localparam logic       ON         = 1'b1;
   localparam logic       OFF        = 1'b0;

   localparam logic [1:0] NORMAL     = 2'd0;
   localparam logic [1:0] STALL      = 2'd1;
   localparam logic [1:0] FLUSH      = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select for the shared bus plus the fetch starvation counter.
// Data wins by default; a fetch that has lost MAX_I_WAIT times wins next.
module arb_pick #(
   parameter int MAX_I_WAIT = 4,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_idle,
   input  logic             i_fetch_req,
   input  logic             i_fetch_kill,
   input  logic             i_data_req,
   output logic             o_pick_i,
   output logic             o_pick_d
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_I_WAIT);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_fetch_elig;
   logic             w_starved;

   // Winner select: a starved fetch overrides the data side's priority.
   always_comb begin
      w_fetch_elig = i_fetch_req & ~i_fetch_kill;
      w_starved    = (r_cnt == MAX_CNT);
      o_pick_i     = i_idle & w_fetch_elig & (~i_data_req | w_starved);
      o_pick_d     = i_idle & i_data_req & ~o_pick_i;
   end

   // Next starvation count: count lost arbitrations, clear on fetch win or flush.
   always_comb begin
      if (i_fetch_kill || o_pick_i) begin
         w_cnt_nxt = {CNT_W{1'b0}};
      end else if (o_pick_d && w_fetch_elig && !w_starved) begin
         w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= {CNT_W{1'b0}};
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between IF fetches and MEM loads/stores,
// one transaction at a time, with registered command and response paths.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int MAX_I_WAIT = 4,
   parameter int CNT_W      = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   input  logic            i_kill,
   output logic            i_ready,
   output logic            i_rvalid,
   output logic [XLEN-1:0] i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [3:0]      d_wstrb,
   output logic            d_ready,
   output logic            d_rvalid,
   output logic [XLEN-1:0] d_rdata,
   output logic            m_req,
   output logic            m_we,
   output logic [XLEN-1:0] m_addr,
   output logic [XLEN-1:0] m_wdata,
   output logic [3:0]      m_wstrb,
   input  logic            m_gnt,
   input  logic            m_rvalid,
   input  logic [XLEN-1:0] m_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE   = ARB_IDLE,
      ST_REQ_I  = ARB_REQ_I,
      ST_WAIT_I = ARB_WAIT_I,
      ST_REQ_D  = ARB_REQ_D,
      ST_WAIT_D = ARB_WAIT_D
   } state_t;

   state_t r_state;
   logic   r_drop;
   logic   w_idle;
   logic   w_pick_i;
   logic   w_pick_d;
   logic   w_i_done;
   logic   w_d_done;
   logic   w_i_squash;

   arb_pick #(
      .MAX_I_WAIT (MAX_I_WAIT),
      .CNT_W      (CNT_W)
   ) u_pick (
      .clk          (clk),
      .rst          (rst),
      .i_idle       (w_idle),
      .i_fetch_req  (i_req),
      .i_fetch_kill (i_kill),
      .i_data_req   (d_req),
      .o_pick_i     (w_pick_i),
      .o_pick_d     (w_pick_d)
   );

   // Response completion: a grant may carry the response in the same cycle.
   always_comb begin
      w_idle     = (r_state == ST_IDLE);
      w_i_squash = r_drop | i_kill;
      w_i_done   = 1'b0;
      w_d_done   = 1'b0;
      case (r_state)
         ST_REQ_I:  w_i_done = m_gnt & m_rvalid;
         ST_WAIT_I: w_i_done = m_rvalid;
         ST_REQ_D:  w_d_done = m_gnt & m_rvalid;
         ST_WAIT_D: w_d_done = m_rvalid;
         default: begin
            w_i_done = 1'b0;
            w_d_done = 1'b0;
         end
      endcase
   end

   // Transaction FSM with registered bus command and requester handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_drop   <= 1'b0;
         i_ready  <= 1'b0;
         i_rvalid <= 1'b0;
         i_rdata  <= {XLEN{1'b0}};
         d_ready  <= 1'b0;
         d_rvalid <= 1'b0;
         d_rdata  <= {XLEN{1'b0}};
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= {XLEN{1'b0}};
         m_wdata  <= {XLEN{1'b0}};
         m_wstrb  <= 4'b0000;
      end else begin
         i_ready  <= 1'b0;
         d_ready  <= 1'b0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_drop <= 1'b0;
               if (w_pick_d) begin
                  m_req   <= 1'b1;
                  m_we    <= d_we;
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
                  m_wstrb <= d_wstrb;
                  d_ready <= 1'b1;
                  r_state <= ST_REQ_D;
               end else if (w_pick_i) begin
                  m_req   <= 1'b1;
                  m_we    <= 1'b0;
                  m_addr  <= i_addr;
                  m_wdata <= {XLEN{1'b0}};
                  m_wstrb <= 4'b0000;
                  i_ready <= 1'b1;
                  r_state <= ST_REQ_I;
               end else begin
                  m_req   <= 1'b0;
               end
            end
            ST_REQ_I, ST_WAIT_I: begin
               if (w_i_done) begin
                  // A flush before or with the response consumes it silently.
                  m_req    <= 1'b0;
                  r_drop   <= 1'b0;
                  i_rvalid <= ~w_i_squash;
                  if (!w_i_squash) begin
                     i_rdata <= m_rdata;
                  end
                  r_state  <= ST_IDLE;
               end else if ((r_state == ST_REQ_I) && m_gnt) begin
                  m_req   <= 1'b0;
                  r_drop  <= w_i_squash;
                  r_state <= ST_WAIT_I;
               end else begin
                  r_drop  <= w_i_squash;
               end
            end
            ST_REQ_D, ST_WAIT_D: begin
               if (w_d_done) begin
                  m_req    <= 1'b0;
                  d_rvalid <= 1'b1;
                  d_rdata  <= m_we ? {XLEN{1'b0}} : m_rdata;
                  r_state  <= ST_IDLE;
               end else if ((r_state == ST_REQ_D) && m_gnt) begin
                  m_req   <= 1'b0;
                  r_state <= ST_WAIT_D;
               end else begin
                  r_state <= r_state;
               end
            end
            default: begin
               m_req   <= 1'b0;
               r_drop  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_kill;
   logic [31:0] i_addr;
   logic        i_ready, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ready, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_gnt, m_rvalid;
   logic [31:0] m_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_i_rdata = 32'h0000_0000;

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(32), .MAX_I_WAIT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
      .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_req = 1'b0; i_kill = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'b0000;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
      tick(); tick();
      n_checks++;
      if ({i_ready, i_rvalid, d_ready, d_rvalid, m_req, m_we, m_wstrb} !== 10'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0", {i_ready, i_rvalid, d_ready, d_rvalid, m_req, m_we, m_wstrb});
      end
      n_checks++;
      if ({i_rdata, d_rdata, m_addr, m_wdata} !== 128'b0) begin
         n_fail++; $display("FAIL reset_data: got %h want 0", {i_rdata, d_rdata, m_addr, m_wdata});
      end
      n_checks++;
      if (dut.r_state !== 3'd0 || dut.u_pick.r_cnt !== 3'd0) begin
         n_fail++; $display("FAIL reset_state: state %0d cnt %0d want 0 0", dut.r_state, dut.u_pick.r_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_fetch_only();
      i_req = 1'b1; i_addr = 32'h0000_0100;
      tick();
      n_checks++;
      if ({i_ready, m_req, m_we, m_wstrb} !== 7'b1100000 || m_addr !== 32'h100) begin
         n_fail++; $display("FAIL fetch_cmd: rdy/req/we/strb %b addr %h want 1100000 100", {i_ready, m_req, m_we, m_wstrb}, m_addr);
      end
      i_req = 1'b0; m_gnt = 1'b1;
      tick();
      n_checks++;
      if ({i_ready, m_req, i_rvalid} !== 3'b000) begin
         n_fail++; $display("FAIL fetch_gnt: rdy/req/rvalid %b want 000", {i_ready, m_req, i_rvalid});
      end
      m_gnt = 1'b0;
      tick();
      n_checks++;
      if ({i_rvalid, m_req} !== 2'b00) begin
         n_fail++; $display("FAIL fetch_wait: rvalid/req %b want 00", {i_rvalid, m_req});
      end
      m_rvalid = 1'b1; m_rdata = 32'h0050_0093;
      tick();
      n_checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'h0050_0093) begin
         n_fail++; $display("FAIL fetch_resp: rvalid %b rdata %h want 1 00500093", i_rvalid, i_rdata);
      end
      last_i_rdata = 32'h0050_0093;
      m_rvalid = 1'b0; m_rdata = 32'hFFFF_FFFF;
      tick();
      n_checks++;
      if (i_rvalid !== 1'b0 || i_ready !== 1'b0 || i_rdata !== last_i_rdata) begin
         n_fail++; $display("FAIL fetch_after: rvalid %b ready %b rdata %h want 0 0 %h", i_rvalid, i_ready, i_rdata, last_i_rdata);
      end
   endtask

   task automatic test_priority();
      i_req = 1'b1; i_addr = 32'h0000_0104;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
      tick();
      n_checks++;
      if ({d_ready, i_ready, m_we} !== 3'b100 || m_addr !== 32'h2000) begin
         n_fail++; $display("FAIL prio_data_first: d/i rdy,we %b addr %h want 100 2000", {d_ready, i_ready, m_we}, m_addr);
      end
      d_req = 1'b0; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
      tick();
      n_checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || i_ready !== 1'b0 || m_req !== 1'b0) begin
         n_fail++; $display("FAIL prio_load: d_rvalid %b d_rdata %h i_ready %b m_req %b want 1 deadbeef 0 0", d_rvalid, d_rdata, i_ready, m_req);
      end
      m_gnt = 1'b0; m_rvalid = 1'b0;
      tick();
      n_checks++;
      if (i_ready !== 1'b1 || m_addr !== 32'h104 || d_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL prio_fetch_next: i_ready %b addr %h d_rvalid %b want 1 104 0", i_ready, m_addr, d_rvalid);
      end
      i_req = 1'b0; m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0013;
      tick();
      n_checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'h13) begin
         n_fail++; $display("FAIL prio_fetch_resp: rvalid %b rdata %h want 1 13", i_rvalid, i_rdata);
      end
      last_i_rdata = 32'h0000_0013;
      m_rvalid = 1'b0;
   endtask

   task automatic test_starvation();
      i_req = 1'b1; i_addr = 32'h0000_0300;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hA5A5_0000; d_wstrb = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (d_ready !== 1'b1 || i_ready !== 1'b0 || dut.u_pick.r_cnt !== 3'(k + 1)) begin
            n_fail++; $display("FAIL starve_loss%0d: d_ready %b i_ready %b cnt %0d want 1 0 %0d", k, d_ready, i_ready, dut.u_pick.r_cnt, k + 1);
         end
         m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1111_1111;
         tick();
         n_checks++;
         if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL starve_ack%0d: d_rvalid %b d_rdata %h want 1 0", k, d_rvalid, d_rdata);
         end
         m_gnt = 1'b0; m_rvalid = 1'b0;
      end
      tick();
      n_checks++;
      if (i_ready !== 1'b1 || d_ready !== 1'b0 || m_addr !== 32'h300 || dut.u_pick.r_cnt !== 3'd0) begin
         n_fail++; $display("FAIL starve_fetch_wins: i_ready %b d_ready %b addr %h cnt %0d want 1 0 300 0", i_ready, d_ready, m_addr, dut.u_pick.r_cnt);
      end
      i_req = 1'b0; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0000_0077;
      tick();
      n_checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'h77) begin
         n_fail++; $display("FAIL starve_fetch_resp: rvalid %b rdata %h want 1 77", i_rvalid, i_rdata);
      end
      last_i_rdata = 32'h0000_0077;
      m_gnt = 1'b0; m_rvalid = 1'b0;
      tick();
      n_checks++;
      if (d_ready !== 1'b1) begin
         n_fail++; $display("FAIL starve_data_resume: d_ready %b want 1", d_ready);
      end
      d_req = 1'b0; m_gnt = 1'b1; m_rvalid = 1'b1;
      tick();
      m_gnt = 1'b0; m_rvalid = 1'b0;
      tick();
   endtask

   task automatic test_kill();
      i_req = 1'b1; i_addr = 32'h0000_0180;
      tick();
      i_req = 1'b0; m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0; i_kill = 1'b1;
      tick();
      i_kill = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0BAD;
      tick();
      n_checks++;
      if (i_rvalid !== 1'b0 || i_rdata !== last_i_rdata || dut.r_state !== 3'd0) begin
         n_fail++; $display("FAIL kill_inflight: rvalid %b rdata %h state %0d want 0 %h 0", i_rvalid, i_rdata, dut.r_state, last_i_rdata);
      end
      m_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0200;
      tick();
      n_checks++;
      if (i_ready !== 1'b1 || m_addr !== 32'h200) begin
         n_fail++; $display("FAIL kill_next_fetch: ready %b addr %h want 1 200", i_ready, m_addr);
      end
      i_req = 1'b0; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0000_0297;
      tick();
      n_checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'h297) begin
         n_fail++; $display("FAIL kill_next_resp: rvalid %b rdata %h want 1 297", i_rvalid, i_rdata);
      end
      last_i_rdata = 32'h0000_0297;
      m_gnt = 1'b0; m_rvalid = 1'b0;
      i_req = 1'b1; i_addr = 32'h0000_0400; i_kill = 1'b1;
      tick();
      n_checks++;
      if (i_ready !== 1'b0 || m_req !== 1'b0) begin
         n_fail++; $display("FAIL kill_idle_block: ready %b m_req %b want 0 0", i_ready, m_req);
      end
      i_kill = 1'b0;
      tick();
      n_checks++;
      if (i_ready !== 1'b1 || m_addr !== 32'h400) begin
         n_fail++; $display("FAIL kill_idle_retry: ready %b addr %h want 1 400", i_ready, m_addr);
      end
      i_req = 1'b0; m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0055; i_kill = 1'b1;
      tick();
      n_checks++;
      if (i_rvalid !== 1'b0 || i_rdata !== last_i_rdata) begin
         n_fail++; $display("FAIL kill_with_rvalid: rvalid %b rdata %h want 0 %h", i_rvalid, i_rdata, last_i_rdata);
      end
      m_rvalid = 1'b0; i_kill = 1'b0;
      tick();
   endtask

   task automatic test_store();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'h0000_1234; d_wstrb = 4'b0011;
      tick();
      n_checks++;
      if ({d_ready, m_req, m_we, m_wstrb} !== 7'b1110011 || m_addr !== 32'h3000 || m_wdata !== 32'h1234) begin
         n_fail++; $display("FAIL store_cmd: rdy/req/we/strb %b addr %h wdata %h want 1110011 3000 1234", {d_ready, m_req, m_we, m_wstrb}, m_addr, m_wdata);
      end
      d_req = 1'b0; d_wstrb = 4'b1100; d_wdata = 32'h0;
      tick();
      n_checks++;
      if ({d_ready, m_req, m_we, m_wstrb} !== 7'b0110011 || m_wdata !== 32'h1234) begin
         n_fail++; $display("FAIL store_hold: rdy/req/we/strb %b wdata %h want 0110011 1234", {d_ready, m_req, m_we, m_wstrb}, m_wdata);
      end
      m_gnt = 1'b1;
      tick();
      n_checks++;
      if (m_req !== 1'b0 || d_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL store_gnt: m_req %b d_rvalid %b want 0 0", m_req, d_rvalid);
      end
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
      tick();
      n_checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin
         n_fail++; $display("FAIL store_ack: d_rvalid %b d_rdata %h want 1 0", d_rvalid, d_rdata);
      end
      m_rvalid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
      tick();
      d_req = 1'b0; m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0; rst = 1'b1;
      tick();
      n_checks++;
      if ({i_ready, i_rvalid, d_ready, d_rvalid, m_req, m_we} !== 6'b0 || {m_addr, d_rdata, i_rdata} !== 96'b0) begin
         n_fail++; $display("FAIL rstmid_outputs: ctrl %b data %h want 0", {i_ready, i_rvalid, d_ready, d_rvalid, m_req, m_we}, {m_addr, d_rdata, i_rdata});
      end
      n_checks++;
      if (dut.r_state !== 3'd0) begin
         n_fail++; $display("FAIL rstmid_state: got %0d want 0", dut.r_state);
      end
      rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_CAFE;
      tick();
      n_checks++;
      if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || m_req !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_late_rvalid: d_rvalid %b d_rdata %h m_req %b want 0 0 0", d_rvalid, d_rdata, m_req);
      end
      m_rvalid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_priority();
      test_starvation();
      test_kill();
      test_store();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
